clint_axil_core: RTL and testbench
==================================

// Module: clint_axil_core
// PURPOSE
//  AXI4-Lite slave core of the CLINT IP: holds the msip, mtimecmp and mtime registers and drives the
//  per-hart software (msip) and timer (mtip) interrupt lines into the hart(s). Sits directly
//  downstream of the block-design AXI master/interconnect and upstream of the core's interrupt inputs.
// PARAMETERS
//  NUM_HARTS   1    harts served, 1..4
//  ADDR_WIDTH  16   AXI address width; byte offsets are decoded from AWADDR/ARADDR[15:0]
//  TICK_DIV    1    ACLK cycles per mtime increment, >=1 (1 = increment every cycle)
// PORTS
//  ACLK           in   1           clock
//  ARESETN        in   1           asynchronous active-low reset
//  S_AXI_AWADDR   in   ADDR_WIDTH  write address
//  S_AXI_AWPROT   in   3           ignored
//  S_AXI_AWVALID  in   1           write address valid
//  S_AXI_AWREADY  out  1           write address ready
//  S_AXI_WDATA    in   32          write data
//  S_AXI_WSTRB    in   4           byte enables
//  S_AXI_WVALID   in   1           write data valid
//  S_AXI_WREADY   out  1           write data ready
//  S_AXI_BRESP    out  2           write response
//  S_AXI_BVALID   out  1           write response valid
//  S_AXI_BREADY   in   1           write response ready
//  S_AXI_ARADDR   in   ADDR_WIDTH  read address
//  S_AXI_ARPROT   in   3           ignored
//  S_AXI_ARVALID  in   1           read address valid
//  S_AXI_ARREADY  out  1           read address ready
//  S_AXI_RDATA    out  32          read data
//  S_AXI_RRESP    out  2           read response
//  S_AXI_RVALID   out  1           read data valid
//  S_AXI_RREADY   in   1           read data ready
//  msip_o         out  NUM_HARTS   software interrupt per hart
//  mtip_o         out  NUM_HARTS   timer interrupt per hart
// BEHAVIOUR
//  Map: 0x0000+4h msip[h] (bit0 only; other bits read 0); 0x4000+8h mtimecmp[h] lo, +4 hi;
//   0xBFF8 mtime lo, 0xBFFC hi. Any other offset, or h>=NUM_HARTS: unmapped.
//  Reset: all READY/VALID outputs 0, BRESP/RRESP/RDATA 0, msip 0, mtimecmp all-ones, mtime 0,
//   prescaler 0, msip_o/mtip_o 0.
//  Write channel: AWREADY=1 while no address is held and BVALID=0; WREADY likewise for data.
//   AW and W are captured independently in either order or the same cycle. The register update
//   occurs in the cycle after both are held. BVALID rises in that same cycle. BVALID holds until
//   BREADY; the holds clear on the B handshake. One write is outstanding at a time.
//  WSTRB is honoured per byte. A write with WSTRB=0 is accepted with OKAY and changes nothing.
//   Unmapped write: BRESP=SLVERR(2'b10), no state change. Mapped: OKAY.
//  Read channel: ARREADY=1 while RVALID=0. On the AR handshake, RDATA/RRESP are registered and
//   RVALID=1 on the next cycle. Both are held until RREADY. Unmapped read: RDATA=0, RRESP=SLVERR.
//  Read/write collision in the same cycle to the same register: the read returns the pre-write value.
//  mtime: 64-bit, wraps 2^64-1 -> 0. It increments when prescaler==TICK_DIV-1; the prescaler then
//   returns to 0. A bus write to mtime lo/hi in a cycle overrides that cycle's increment for the
//   written half. The other half still carries normally. The prescaler is unaffected.
//  mtip_o[h] = registered (mtime >= mtimecmp[h]), unsigned 64-bit compare, so it lags by 1 cycle.
//   It clears one cycle after the compare becomes false (e.g. a mtimecmp write).
//  msip_o[h] = msip[h] bit0 directly from the register, with no extra delay.
//  A reset assertion mid-transaction immediately drops all VALID/READY outputs and discards held
//   AW/W/AR state. No response is produced for the aborted transaction.
// TESTING
//  1. Reset release, idle 10 cycles -> AWREADY=WREADY=ARREADY=1; BVALID=RVALID=0; msip_o=mtip_o=0;
//     read 0x4000/0x4004 -> 0xFFFFFFFF OKAY.
//  2. Write 0x00000001 to 0x0000, then read it -> msip_o[0]=1 one cycle after the B handshake;
//     read 0x0000 -> 0x00000001. Write 0xFFFFFFFE -> msip_o[0]=0; read -> 0x0.
//  3. Write W one cycle before AW, then the reverse order, with BREADY held low 5 cycles -> one
//     BVALID per write, held stable, BRESP=OKAY; no second AW accepted while BVALID=1.
//  4. TICK_DIV=4: write mtime=0, write mtimecmp[0] hi=0 and lo=0x10 -> mtip_o[0]=1 after the
//     (0x10*4)+1 cycles following the mtime write. Write mtimecmp lo=0xFFFFFFFF -> mtip_o drops next cycle.
//  5. Write mtime lo=0xFFFFFFFF, hi=0x0 -> carry gives hi=1, lo=0 after the next tick.
//     Write mtime lo/hi to all-ones -> wraps to 0.
//  6. Access 0x0100 and 0x2000 (also 0x0004 with NUM_HARTS=1) -> SLVERR, RDATA=0, no state change.
//     A WSTRB=4'b0010 write of 0xAABBCCDD to mtimecmp lo changes only byte1 to 0xCC.

Source files
------------

// File: rtl/clint_axil_core.sv
// AXI4-Lite slave for the CLINT: msip, mtimecmp and mtime registers.
// Drives the per-hart software (msip_o) and timer (mtip_o) interrupt lines.
module clint_axil_core #(
    parameter int NUM_HARTS  = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int TICK_DIV   = 1
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [NUM_HARTS-1:0]  msip_o,
    output logic [NUM_HARTS-1:0]  mtip_o
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {K_NONE, K_MSIP, K_CMP_LO, K_CMP_HI, K_TIME_LO, K_TIME_HI} reg_kind_e;

    // Only word-aligned offsets are mapped; harts beyond NUM_HARTS fall through to K_NONE.
    function automatic reg_kind_e decode_kind(input logic [15:0] off);
        reg_kind_e k;
        k = K_NONE;
        if (off[1:0] == 2'b00) begin
            if (off[15:4] == 12'h000 && int'(off[3:2]) < NUM_HARTS)
                k = K_MSIP;
            else if (off[15:5] == 11'h200 && int'(off[4:3]) < NUM_HARTS)
                k = off[2] ? K_CMP_HI : K_CMP_LO;
            else if (off == 16'hBFF8)
                k = K_TIME_LO;
            else if (off == 16'hBFFC)
                k = K_TIME_HI;
        end
        return k;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    logic                 alive;
    logic                 aw_held, w_held, bvalid_q, rvalid_q;
    logic [15:0]          aw_off_q;
    logic [31:0]          w_data_q, rdata_q;
    logic [3:0]           w_strb_q;
    logic [1:0]           bresp_q, rresp_q;
    logic [NUM_HARTS-1:0] msip_q, mtip_q;
    logic [63:0]          mtimecmp_q [NUM_HARTS];
    logic [63:0]          mtime_q, mtime_nxt;
    logic [PW-1:0]        presc_q;
    logic                 tick;
    logic                 wr_fire;
    reg_kind_e            wr_kind, rd_kind;
    logic [1:0]           wr_hart, rd_hart;
    logic [31:0]          rd_word;
    logic                 awready, wready, arready;
    logic                 unused_prot;

    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // alive keeps every READY low while reset is asserted and for the first edge after.
    assign awready = alive && !aw_held && !bvalid_q;
    assign wready  = alive && !w_held && !bvalid_q;
    assign arready = alive && !rvalid_q;

    assign wr_fire = aw_held && w_held && !bvalid_q;
    assign wr_kind = decode_kind(aw_off_q);
    assign wr_hart = (wr_kind == K_MSIP) ? aw_off_q[3:2] : aw_off_q[4:3];
    assign tick    = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        rd_kind = decode_kind(S_AXI_ARADDR[15:0]);
        rd_hart = (rd_kind == K_MSIP) ? S_AXI_ARADDR[3:2] : S_AXI_ARADDR[4:3];
        rd_word = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (int'(rd_hart) == h) begin
                if (rd_kind == K_MSIP)   rd_word = {31'd0, msip_q[h]};
                if (rd_kind == K_CMP_LO) rd_word = mtimecmp_q[h][31:0];
                if (rd_kind == K_CMP_HI) rd_word = mtimecmp_q[h][63:32];
            end
        end
        if (rd_kind == K_TIME_LO) rd_word = mtime_q[31:0];
        if (rd_kind == K_TIME_HI) rd_word = mtime_q[63:32];
    end

    // A bus write replaces only the written half; the carry into the other half still applies.
    always_comb begin
        mtime_nxt = mtime_q + {63'd0, tick};
        if (wr_fire && wr_kind == K_TIME_LO)
            mtime_nxt[31:0] = merge_bytes(mtime_q[31:0], w_data_q, w_strb_q);
        if (wr_fire && wr_kind == K_TIME_HI)
            mtime_nxt[63:32] = merge_bytes(mtime_q[63:32], w_data_q, w_strb_q);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            alive    <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_off_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            alive <= 1'b1;
            if (S_AXI_AWVALID && awready) begin
                aw_held  <= 1'b1;
                aw_off_q <= S_AXI_AWADDR[15:0];
            end
            if (S_AXI_WVALID && wready) begin
                w_held   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (wr_fire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (wr_kind == K_NONE) ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (S_AXI_ARVALID && arready) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word;
            rresp_q  <= (rd_kind == K_NONE) ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            msip_q  <= '0;
            mtip_q  <= '0;
            mtime_q <= '0;
            presc_q <= '0;
            for (int h = 0; h < NUM_HARTS; h++)
                mtimecmp_q[h] <= '1;
        end else begin
            mtime_q <= mtime_nxt;
            presc_q <= tick ? '0 : presc_q + 1'b1;
            for (int h = 0; h < NUM_HARTS; h++) begin
                mtip_q[h] <= (mtime_q >= mtimecmp_q[h]);
                if (wr_fire && int'(wr_hart) == h) begin
                    if (wr_kind == K_MSIP && w_strb_q[0])
                        msip_q[h] <= w_data_q[0];
                    if (wr_kind == K_CMP_LO)
                        mtimecmp_q[h][31:0] <= merge_bytes(mtimecmp_q[h][31:0], w_data_q, w_strb_q);
                    if (wr_kind == K_CMP_HI)
                        mtimecmp_q[h][63:32] <= merge_bytes(mtimecmp_q[h][63:32], w_data_q, w_strb_q);
                end
            end
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign msip_o        = msip_q;
    assign mtip_o        = mtip_q;
endmodule

// File: tb/tb_clint_axil_core.sv
// Bench for clint_axil_core (one hart, TICK_DIV=4) against a closed-form register/timer model.
module tb_clint_axil_core;
    localparam int TICK = 4;

    logic        ACLK = 1'b0, ARESETN = 1'b0;
    logic [15:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
    logic        S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_BREADY = 1'b0;
    logic        S_AXI_ARVALID = 1'b0, S_AXI_RREADY = 1'b0;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;
    logic [0:0]  msip_o, mtip_o;

    int checks = 0, failures = 0;
    int cyc;

    logic        m_msip;
    logic [63:0] m_cmp, m_tval;
    int          m_tk;

    clint_axil_core #(.NUM_HARTS(1), .ADDR_WIDTH(16), .TICK_DIV(TICK)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
        .S_AXI_RREADY(S_AXI_RREADY), .msip_o(msip_o), .mtip_o(mtip_o)
    );

    always #5 ACLK = ~ACLK;

    // cyc = number of rising edges since reset release
    always @(posedge ACLK or negedge ARESETN)
        if (!ARESETN) cyc <= 0;
        else          cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic int kind_of(input logic [15:0] a);
        if (a == 16'h0000) return 1;
        if (a == 16'h4000) return 2;
        if (a == 16'h4004) return 3;
        if (a == 16'hBFF8) return 4;
        if (a == 16'hBFFC) return 5;
        return 0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    // mtime after edge k: one increment on every edge whose index is a multiple of TICK
    function automatic logic [63:0] mtime_at(input int k);
        return m_tval + 64'(k / TICK - m_tk / TICK);
    endfunction

    function automatic void model_reset();
        m_msip = 1'b0;
        m_cmp  = '1;
        m_tval = '0;
        m_tk   = 0;
    endfunction

    function automatic logic [1:0] model_write(input logic [15:0] a, input logic [31:0] d,
                                               input logic [3:0] s, input int kw);
        logic [63:0] prev, inc;
        prev = mtime_at(kw - 1);
        inc  = mtime_at(kw);
        case (kind_of(a))
            1: if (s[0]) m_msip = d[0];
            2: m_cmp[31:0]  = merge(m_cmp[31:0], d, s);
            3: m_cmp[63:32] = merge(m_cmp[63:32], d, s);
            4: begin m_tval = {inc[63:32], merge(prev[31:0], d, s)}; m_tk = kw; end
            5: begin m_tval = {merge(prev[63:32], d, s), inc[31:0]}; m_tk = kw; end
            default: return 2'b10;
        endcase
        return 2'b00;
    endfunction

    function automatic void model_read(input logic [15:0] a, input int ka,
                                       output logic [31:0] d, output logic [1:0] r);
        logic [63:0] t;
        t = mtime_at(ka - 1);
        r = 2'b00;
        case (kind_of(a))
            1: d = {31'd0, m_msip};
            2: d = m_cmp[31:0];
            3: d = m_cmp[63:32];
            4: d = t[31:0];
            5: d = t[63:32];
            default: begin d = '0; r = 2'b10; end
        endcase
    endfunction

    // ---------------- bus tasks (enter and leave at posedge+1) ----------------
    // mode: 0 = AW and W together, 1 = W one cycle before AW, 2 = AW one cycle before W
    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int mode, input int hold,
                             output logic [1:0] resp, output int kw, output int bad);
        int n;
        bad = 0;
        S_AXI_AWADDR  = a;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_WVALID  = (mode != 2);
        S_AXI_AWVALID = (mode != 1);
        @(posedge ACLK); #1;
        if (mode != 0) begin
            S_AXI_WVALID  = (mode == 2);
            S_AXI_AWVALID = (mode == 1);
            @(posedge ACLK); #1;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        n = 0;
        while (S_AXI_BVALID !== 1'b1 && n < 20) begin
            @(posedge ACLK); #1;
            n++;
        end
        checks++;
        if (S_AXI_BVALID !== 1'b1) begin
            failures++;
            $display("FAIL write_timeout addr=%h: bvalid=%b expected 1", a, S_AXI_BVALID);
        end
        kw   = cyc;
        resp = S_AXI_BRESP;
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                S_AXI_AWADDR  = 16'h4004;
                S_AXI_AWVALID = 1'b1;
            end
            @(posedge ACLK); #1;
            if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== resp || S_AXI_AWREADY !== 1'b0 || S_AXI_WREADY !== 1'b0)
                bad++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_BREADY  = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY  = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output int ka);
        int n;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (S_AXI_RVALID !== 1'b1 && n < 20) begin
            @(posedge ACLK); #1;
            n++;
        end
        checks++;
        if (S_AXI_RVALID !== 1'b1) begin
            failures++;
            $display("FAIL read_timeout addr=%h: rvalid=%b expected 1", a, S_AXI_RVALID);
        end
        ka   = cyc - n;
        d    = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] rd, ed;
        logic [1:0]  rr, er;
        int ka;
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP,
             S_AXI_RRESP, S_AXI_RDATA, msip_o, mtip_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: aw=%b w=%b ar=%b b=%b r=%b rdata=%h expected all 0",
                     S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA);
        end
        ARESETN = 1'b1;
        model_reset();
        repeat (10) @(posedge ACLK);
        #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, msip_o, mtip_o} !== 7'b1110000) begin
            failures++;
            $display("FAIL idle_handshake: aw=%b w=%b ar=%b b=%b r=%b msip=%b mtip=%b expected 1 1 1 0 0 0 0",
                     S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, msip_o, mtip_o);
        end
        foreach (ed[i]) ed[i] = 1'b1;
        axi_read(16'h4000, rd, rr, ka);
        checks++;
        if (rd !== ed || rr !== 2'b00) begin
            failures++;
            $display("FAIL reset_cmp_lo: got %h/%b expected %h/00", rd, rr, ed);
        end
        axi_read(16'h4004, rd, rr, ka);
        checks++;
        if (rd !== ed || rr !== 2'b00) begin
            failures++;
            $display("FAIL reset_cmp_hi: got %h/%b expected %h/00", rd, rr, ed);
        end
        axi_read(16'hBFF8, rd, rr, ka);
        model_read(16'hBFF8, ka, ed, er);
        checks++;
        if (rd !== ed || rr !== er) begin
            failures++;
            $display("FAIL reset_mtime_lo: got %h/%b expected %h/%b", rd, rr, ed, er);
        end
    endtask

    task automatic test_msip();
        logic [31:0] rd, ed, d;
        logic [1:0]  rr, er, resp;
        logic [3:0]  s;
        int kw, ka, bad;
        axi_write(16'h0000, 32'h1, 4'hF, 0, 0, resp, kw, bad);
        void'(model_write(16'h0000, 32'h1, 4'hF, kw));
        checks++;
        if (msip_o !== 1'b1 || resp !== 2'b00) begin
            failures++;
            $display("FAIL msip_set: msip=%b resp=%b expected 1/00", msip_o, resp);
        end
        axi_read(16'h0000, rd, rr, ka);
        checks++;
        if (rd !== 32'h1 || rr !== 2'b00) begin
            failures++;
            $display("FAIL msip_read1: got %h/%b expected 00000001/00", rd, rr);
        end
        axi_write(16'h0000, 32'hFFFFFFFE, 4'hF, 0, 0, resp, kw, bad);
        void'(model_write(16'h0000, 32'hFFFFFFFE, 4'hF, kw));
        axi_read(16'h0000, rd, rr, ka);
        checks++;
        if (msip_o !== 1'b0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL msip_clear: msip=%b read=%h expected 0/00000000", msip_o, rd);
        end
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(16'h0000, d, s, 0, 0, resp, kw, bad);
            void'(model_write(16'h0000, d, s, kw));
            axi_read(16'h0000, rd, rr, ka);
            model_read(16'h0000, ka, ed, er);
            checks++;
            if (msip_o !== m_msip || rd !== ed) begin
                failures++;
                $display("FAIL msip_random d=%h s=%b: msip=%b read=%h expected %b/%h", d, s, msip_o, rd, m_msip, ed);
            end
        end
    endtask

    task automatic test_write_order();
        logic [31:0] rd, ed, d;
        logic [1:0]  rr, er, resp;
        int kw, ka, bad;
        for (int mode = 1; mode <= 2; mode++) begin
            d = $urandom;
            axi_write(16'h4000, d, 4'hF, mode, 5, resp, kw, bad);
            er = model_write(16'h4000, d, 4'hF, kw);
            checks++;
            if (resp !== er || bad !== 0) begin
                failures++;
                $display("FAIL order_mode%0d: resp=%b hold_violations=%0d expected %b/0", mode, resp, bad, er);
            end
            axi_read(16'h4000, rd, rr, ka);
            model_read(16'h4000, ka, ed, er);
            checks++;
            if (rd !== ed || rr !== er) begin
                failures++;
                $display("FAIL order_read_mode%0d: got %h/%b expected %h/%b", mode, rd, rr, ed, er);
            end
        end
    endtask

    task automatic test_timer();
        logic [1:0] resp;
        logic       exp_t;
        int kw, bad, errs, seen;
        axi_write(16'hBFF8, 32'h0, 4'hF, 0, 0, resp, kw, bad); void'(model_write(16'hBFF8, 32'h0, 4'hF, kw));
        axi_write(16'hBFFC, 32'h0, 4'hF, 0, 0, resp, kw, bad); void'(model_write(16'hBFFC, 32'h0, 4'hF, kw));
        axi_write(16'h4004, 32'h0, 4'hF, 0, 0, resp, kw, bad); void'(model_write(16'h4004, 32'h0, 4'hF, kw));
        axi_write(16'h4000, 32'h10, 4'hF, 0, 0, resp, kw, bad); void'(model_write(16'h4000, 32'h10, 4'hF, kw));
        errs = 0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge ACLK); #1;
            exp_t = (mtime_at(cyc - 1) >= m_cmp);
            if (mtip_o[0] !== exp_t) begin
                if (errs == 0) $display("FAIL mtip_track cycle %0d: mtip=%b expected %b", cyc, mtip_o[0], exp_t);
                errs++;
            end
            if (mtip_o[0] === 1'b1) seen = 1;
        end
        checks++;
        if (errs != 0) failures++;
        checks++;
        if (seen != 1) begin
            failures++;
            $display("FAIL mtip_rise: seen=%0d expected 1", seen);
        end
        axi_write(16'h4000, 32'hFFFFFFFF, 4'hF, 0, 0, resp, kw, bad);
        void'(model_write(16'h4000, 32'hFFFFFFFF, 4'hF, kw));
        checks++;
        if (mtip_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL mtip_drop: mtip=%b expected 0", mtip_o[0]);
        end
    endtask

    task automatic test_carry();
        logic [31:0] rd, ed, d;
        logic [1:0]  rr, er, resp;
        logic [15:0] a;
        int kw, ka, bad;
        axi_write(16'hBFFC, 32'h0, 4'hF, 0, 0, resp, kw, bad);        void'(model_write(16'hBFFC, 32'h0, 4'hF, kw));
        axi_write(16'hBFF8, 32'hFFFFFFFF, 4'hF, 0, 0, resp, kw, bad); void'(model_write(16'hBFF8, 32'hFFFFFFFF, 4'hF, kw));
        repeat (5) @(posedge ACLK);
        #1;
        axi_read(16'hBFFC, rd, rr, ka);
        model_read(16'hBFFC, ka, ed, er);
        checks++;
        if (rd !== ed || rd !== 32'h1) begin
            failures++;
            $display("FAIL carry_hi: got %h expected %h", rd, ed);
        end
        axi_write(16'hBFFC, 32'hFFFFFFFF, 4'hF, 0, 0, resp, kw, bad); void'(model_write(16'hBFFC, 32'hFFFFFFFF, 4'hF, kw));
        axi_write(16'hBFF8, 32'hFFFFFFFF, 4'hF, 0, 0, resp, kw, bad); void'(model_write(16'hBFF8, 32'hFFFFFFFF, 4'hF, kw));
        repeat (5) @(posedge ACLK);
        #1;
        axi_read(16'hBFFC, rd, rr, ka);
        model_read(16'hBFFC, ka, ed, er);
        checks++;
        if (rd !== ed || rd !== 32'h0) begin
            failures++;
            $display("FAIL wrap_hi: got %h expected %h", rd, ed);
        end
        for (int i = 0; i < 6; i++) begin
            a = ($urandom_range(0, 1) == 0) ? 16'hBFF8 : 16'hBFFC;
            d = $urandom;
            axi_write(a, d, 4'hF, 0, 0, resp, kw, bad);
            void'(model_write(a, d, 4'hF, kw));
            repeat ($urandom_range(0, 6)) @(posedge ACLK);
            #1;
            a = ($urandom_range(0, 1) == 0) ? 16'hBFF8 : 16'hBFFC;
            axi_read(a, rd, rr, ka);
            model_read(a, ka, ed, er);
            checks++;
            if (rd !== ed || rr !== er) begin
                failures++;
                $display("FAIL mtime_random %h: got %h/%b expected %h/%b", a, rd, rr, ed, er);
            end
        end
    endtask

    task automatic test_unmapped();
        logic [15:0] list [6] = '{16'h0100, 16'h2000, 16'h0004, 16'h4008, 16'hBFF0, 16'h4002};
        logic [31:0] rd, ed, before_lo, before_hi;
        logic [1:0]  rr, er, resp;
        logic        before_msip;
        int kw, ka, bad;
        before_lo   = m_cmp[31:0];
        before_hi   = m_cmp[63:32];
        before_msip = m_msip;
        foreach (list[i]) begin
            axi_write(list[i], $urandom, 4'hF, 0, 0, resp, kw, bad);
            er = model_write(list[i], 32'h0, 4'hF, kw);
            axi_read(list[i], rd, rr, ka);
            checks++;
            if (resp !== 2'b10 || rr !== 2'b10 || rd !== 32'h0 || er !== 2'b10) begin
                failures++;
                $display("FAIL unmapped %h: bresp=%b rresp=%b rdata=%h expected 10/10/00000000", list[i], resp, rr, rd);
            end
        end
        axi_read(16'h4000, rd, rr, ka);
        checks++;
        if (rd !== before_lo) begin
            failures++;
            $display("FAIL unmapped_side_effect_lo: got %h expected %h", rd, before_lo);
        end
        axi_read(16'h4004, rd, rr, ka);
        checks++;
        if (rd !== before_hi || msip_o !== before_msip) begin
            failures++;
            $display("FAIL unmapped_side_effect: hi=%h msip=%b expected %h/%b", rd, msip_o, before_hi, before_msip);
        end
        axi_write(16'h4000, 32'h11223344, 4'hF, 0, 0, resp, kw, bad);   void'(model_write(16'h4000, 32'h11223344, 4'hF, kw));
        axi_write(16'h4000, 32'hAABBCCDD, 4'b0010, 0, 0, resp, kw, bad); void'(model_write(16'h4000, 32'hAABBCCDD, 4'b0010, kw));
        axi_read(16'h4000, rd, rr, ka);
        checks++;
        if (rd !== 32'h1122CC44 || resp !== 2'b00) begin
            failures++;
            $display("FAIL wstrb_byte1: got %h/%b expected 1122CC44/00", rd, resp);
        end
        axi_write(16'h4004, 32'h5A5A5A5A, 4'b0000, 0, 0, resp, kw, bad);
        er = model_write(16'h4004, 32'h5A5A5A5A, 4'b0000, kw);
        axi_read(16'h4004, rd, rr, ka);
        model_read(16'h4004, ka, ed, er);
        checks++;
        if (resp !== 2'b00 || rd !== ed || rd !== before_hi) begin
            failures++;
            $display("FAIL wstrb_zero: resp=%b read=%h expected 00/%h", resp, rd, ed);
        end
    endtask

    task automatic test_collision();
        logic [31:0] rd, ed, old, nd;
        logic [1:0]  rr, er;
        int ka;
        old = m_cmp[31:0];
        nd  = $urandom;
        S_AXI_AWADDR  = 16'h4000;
        S_AXI_WDATA   = nd;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARADDR  = 16'h4000;
        S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        checks++;
        if (S_AXI_BVALID !== 1'b1 || S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== old) begin
            failures++;
            $display("FAIL collision: bvalid=%b rvalid=%b rdata=%h expected 1/1/%h", S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA, old);
        end
        void'(model_write(16'h4000, nd, 4'hF, cyc));
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        axi_read(16'h4000, rd, rr, ka);
        model_read(16'h4000, ka, ed, er);
        checks++;
        if (rd !== ed || rd !== nd) begin
            failures++;
            $display("FAIL collision_after: got %h expected %h", rd, ed);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, ed, wd;
        logic [1:0]  rr, er;
        int n, bseen;
        S_AXI_AWADDR  = 16'h4000;
        S_AXI_AWVALID = 1'b1;
        S_AXI_ARADDR  = 16'h4000;
        S_AXI_ARVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_ARVALID = 1'b0;
        #2;
        ARESETN = 1'b0;
        #1;
        checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, msip_o, mtip_o} !== '0) begin
            failures++;
            $display("FAIL reset_mid: aw=%b w=%b ar=%b b=%b r=%b expected all 0",
                     S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID);
        end
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        model_reset();
        wd = $urandom;
        S_AXI_WDATA  = wd;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        bseen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge ACLK); #1;
            if (S_AXI_WREADY === 1'b0) S_AXI_WVALID = 1'b0;
            if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0) bseen++;
        end
        S_AXI_WVALID = 1'b0;
        checks++;
        if (bseen != 0) begin
            failures++;
            $display("FAIL aborted_txn_response: stray valid cycles=%0d expected 0", bseen);
        end
        S_AXI_AWADDR  = 16'h4004;
        S_AXI_AWVALID = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        n = 0;
        while (S_AXI_BVALID !== 1'b1 && n < 20) begin
            @(posedge ACLK); #1;
            n++;
        end
        er = model_write(16'h4004, wd, 4'hF, cyc);
        checks++;
        if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== er) begin
            failures++;
            $display("FAIL post_reset_write: bvalid=%b bresp=%b expected 1/%b", S_AXI_BVALID, S_AXI_BRESP, er);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        axi_read(16'h4004, rd, rr, n);
        model_read(16'h4004, n, ed, er);
        checks++;
        if (rd !== ed || rr !== er) begin
            failures++;
            $display("FAIL post_reset_read: got %h/%b expected %h/%b", rd, rr, ed, er);
        end
    endtask

    task automatic test_random();
        logic [15:0] pool [10] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC,
                                    16'h0004, 16'h0100, 16'h2000, 16'h4008, 16'hBFF4};
        logic [15:0] a;
        logic [31:0] d, rd, ed;
        logic [3:0]  s;
        logic [1:0]  resp, rr, er;
        int kw, ka, bad;
        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 10) == 10) ? 16'($urandom) : pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = (kind_of(a) >= 4) ? 4'hF : 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 2), 0, resp, kw, bad);
                er = model_write(a, d, s, kw);
                checks++;
                if (resp !== er || msip_o !== m_msip) begin
                    failures++;
                    $display("FAIL random_write %h: bresp=%b msip=%b expected %b/%b", a, resp, msip_o, er, m_msip);
                end
            end else begin
                axi_read(a, rd, rr, ka);
                model_read(a, ka, ed, er);
                checks++;
                if (rd !== ed || rr !== er) begin
                    failures++;
                    $display("FAIL random_read %h: got %h/%b expected %h/%b", a, rd, rr, ed, er);
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_msip();
        test_write_order();
        test_timer();
        test_carry();
        test_unmapped();
        test_collision();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
